// File: rtl/cmd_entry_pkg.sv
// rtl/cmd_entry_pkg.sv - shared select codes, phase codes and state encoding for the command-entry sequencer
package cmd_entry_pkg;

    localparam logic [1:0] SEL_OP_A   = 2'b00;
    localparam logic [1:0] SEL_OP_B   = 2'b01;
    localparam logic [1:0] SEL_RESULT = 2'b10;

    localparam logic [1:0] PHASE_A      = 2'd0;
    localparam logic [1:0] PHASE_B      = 2'd1;
    localparam logic [1:0] PHASE_RESULT = 2'd2;
    localparam logic [1:0] PHASE_DONE   = 2'd3;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        STROBE_A = 3'd1,
        ENTER_B  = 3'd2,
        STROBE_B = 3'd3,
        WAIT     = 3'd4,
        STROBE_R = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Operator-visible phase for a given sequencer state.
    function automatic logic [1:0] state_phase(input state_t s);
        case (s)
            ENTER_A, STROBE_A: state_phase = PHASE_A;
            ENTER_B, STROBE_B: state_phase = PHASE_B;
            WAIT, STROBE_R:    state_phase = PHASE_RESULT;
            default:           state_phase = PHASE_DONE;
        endcase
    endfunction

    // States in which key entries are not accepted.
    function automatic logic state_busy(input state_t s);
        state_busy = (s == STROBE_A) || (s == STROBE_B) || (s == WAIT) || (s == STROBE_R);
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - key level register and single-cycle rising-edge pulse
module key_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_edge
);

    logic key_q;

    // Track the previous key level every cycle, regardless of what the sequencer is doing.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_in;
        end
    end

    assign key_edge = key_in & ~key_q;

endmodule

// File: rtl/cmd_entry_seq.sv
// rtl/cmd_entry_seq.sv - chunked operand entry and A/B/result load strobe sequencer (optional abort: CMD_ENTRY_ABORT_EN)
module cmd_entry_seq
    import cmd_entry_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SW_W        = 8,
    parameter int RESULT_WAIT = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                key_in,
    input  logic [SW_W-1:0]                     sw_in,
`ifdef CMD_ENTRY_ABORT_EN
    input  logic                                abort_in,
`endif
    output logic                                enable,
    output logic [1:0]                          select,
    output logic [DATA_W-1:0]                   data_out,
    output logic [1:0]                          phase,
    output logic [$clog2(DATA_W/SW_W+1)-1:0]    chunk_cnt,
    output logic                                busy
);

    localparam int CHUNKS = DATA_W / SW_W;
    localparam int CNT_W  = $clog2(CHUNKS + 1);
    localparam int WAIT_W = $clog2(RESULT_WAIT + 1);

    state_t              state;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shift_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                key_edge;
    logic                abort;

    key_edge_det u_key_edge_det (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_edge (key_edge)
    );

`ifdef CMD_ENTRY_ABORT_EN
    assign abort = abort_in;
`else
    assign abort = 1'b0;
`endif

    // New chunk enters at the bottom so the first chunk entered ends up in the MSBs.
    always_comb begin
        shift_next = (shift << SW_W) | DATA_W'(sw_in);
    end

    // Phase and busy are pure decodes of the registered state.
    always_comb begin
        phase = state_phase(state);
        busy  = state_busy(state);
    end

    // Sequencer: chunk accumulation, load strobes and the ALU settle wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENTER_A;
            enable    <= 1'b0;
            select    <= SEL_OP_A;
            data_out  <= '0;
            shift     <= '0;
            chunk_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            enable   <= 1'b0;
            data_out <= '0;
            case (state)
                ENTER_A, ENTER_B: begin
                    if (abort) begin
                        shift     <= '0;
                        chunk_cnt <= '0;
                        state     <= ENTER_A;
                    end else if (key_edge) begin
                        shift     <= shift_next;
                        chunk_cnt <= chunk_cnt + 1'b1;
                        if (chunk_cnt == CNT_W'(CHUNKS - 1)) begin
                            state <= (state == ENTER_A) ? STROBE_A : STROBE_B;
                        end
                    end
                end
                STROBE_A: begin
                    enable    <= 1'b1;
                    select    <= SEL_OP_A;
                    data_out  <= shift;
                    shift     <= '0;
                    chunk_cnt <= '0;
                    state     <= ENTER_B;
                end
                STROBE_B: begin
                    enable    <= 1'b1;
                    select    <= SEL_OP_B;
                    data_out  <= shift;
                    shift     <= '0;
                    chunk_cnt <= '0;
                    wait_cnt  <= WAIT_W'(RESULT_WAIT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= STROBE_R;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                STROBE_R: begin
                    enable <= 1'b1;
                    select <= SEL_RESULT;
                    state  <= DONE;
                end
                DONE: begin
                    // The restarting key press only restarts; its chunk is not kept.
                    if (abort || key_edge) begin
                        shift     <= '0;
                        chunk_cnt <= '0;
                        state     <= ENTER_A;
                    end
                end
                default: begin
                    state <= ENTER_A;
                end
            endcase
        end
    end

endmodule
